ksa_multicycle_add_ctrl: RTL
============================

Name: ksa_multicycle_add_ctrl

Overview:
- Sequencer that performs one WIDTH-bit add or subtract by reusing a single SLICE-bit Kogge-Stone slice over WIDTH/SLICE cycles.
- Carry is chained between slices through a register.
- Sits between a requester and a consumer, with valid/ready handshakes on both sides.
- Trades latency for area compared with a full-width Kogge-Stone adder.

Parameters:
- WIDTH, 32, operand/result width; must be an integer multiple of SLICE and at least SLICE.
- SLICE, 8, width of the shared Kogge-Stone slice.
- NSLICE, WIDTH/SLICE, derived; number of slice passes per operation; not user-overridable.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- in1  input  WIDTH  operand A.
- in2  input  WIDTH  operand B.
- cin  input  1  carry-in for add; ignored when sub=1.
- sub  input  1  1 = compute in1 - in2.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out  output  WIDTH  registered sum/difference.
- cout  output  1  final carry-out; for sub, 1 = no borrow.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high.
- Reset values: state = IDLE, out = 0, cout = 0, out_valid = 0, busy = 0. Internal operand/result registers are cleared, slice index = 0, carry register = 0.
- in_ready = 1 exactly when state = IDLE, including the first cycle after reset deasserts.
- FSM states:
  - IDLE: on in_valid & in_ready, capture a = in1, b = sub ? ~in2 : in2, and carry = sub ? 1 : cin. Set idx = 0, go to RUN. Without a handshake, stay in IDLE.
  - RUN: each cycle, the slice adds a[idx*SLICE +: SLICE] + b[idx*SLICE +: SLICE] + carry. The slice sum is written into result[idx*SLICE +: SLICE], carry takes the slice carry-out, and idx increments. When idx == NSLICE-1, the next state is DONE, and out and cout are loaded from the completed result and final carry on that same edge.
  - DONE: out_valid = 1. out and cout are held stable while out_valid & !out_ready. On out_valid & out_ready, go to IDLE and clear out_valid. out and cout keep their last values.
- Latency: request accepted on edge T; RUN occupies edges T+1 .. T+NSLICE; out_valid is high from edge T+NSLICE. Default: 4 RUN cycles.
- Throughput: one operation per NSLICE+2 cycles minimum. Requests do not overlap.
- in_ready is 0 in DONE. A new request cannot be accepted in the same cycle as the output handshake; the earliest accept is the following cycle in IDLE.
- Operands on in1/in2/cin/sub may change freely after acceptance; only captured copies are used.
- Arithmetic: result is modulo 2^WIDTH. cout is the carry out of bit WIDTH-1.
- Degenerate case NSLICE = 1: a single RUN cycle, then DONE.
- Reset in RUN or DONE: the operation is discarded, no out_valid pulse is produced, and the block is back in IDLE with in_ready = 1 the cycle after rst deasserts.
- out_ready is ignored outside DONE. in_valid is ignored outside IDLE.

Decomposition:
- Package ksa_ctrl_pkg: state enum (IDLE, RUN, DONE), default SLICE constant, and a helper function computing the index width, clog2(NSLICE) with a minimum of 1.
- Sub-module ksa_slice_cin: combinational SLICE-bit Kogge-Stone adder with carry-in.
  - Ports in1, in2, cin, out, cout.
  - Carry-in folded into bit 0 generate.
  - Prefix tree with log2(SLICE) levels.
- The controller instantiates exactly one ksa_slice_cin.

Test Plan:
1. Add with full carry ripple: in1 = 0xFFFFFFFF, in2 = 0x00000001, cin = 0, sub = 0, accepted at edge T -> out_valid at T+4, out = 0x00000000, cout = 1.
2. Subtract with borrow: in1 = 5, in2 = 7, sub = 1, cin = 1 (must be ignored) -> out = 0xFFFFFFFE, cout = 0. Second case: in1 = 7, in2 = 5 -> out = 0x00000002, cout = 1.
3. Carry-in crossing a slice boundary: in1 = 0x000000FF, in2 = 0, cin = 1 -> out = 0x00000100, cout = 0.
4. Backpressure: hold out_ready = 0 for 5 cycles after out_valid, with in_valid held high and new operands driven -> out stays stable, in_ready stays 0, no second accept. Raise out_ready -> IDLE next cycle, then the second request is accepted and completes correctly.
5. Reset mid-operation: assert rst for 1 cycle during the second RUN cycle -> out_valid never rises, out = 0, in_ready = 1 after reset. A fresh request 0x12345678 + 0x11111111 -> out = 0x23456789, cout = 0.
6. Single-slice configuration, WIDTH = 8: 0x80 + 0x80 -> out_valid 1 cycle after RUN, out = 0x00, cout = 1. Back-to-back requests are spaced exactly 3 cycles apart with out_ready tied high.

Source files
------------

// File: rtl/ksa_multicycle_add_ctrl_pkg.sv
// Shared types and helpers for the multi-cycle Kogge-Stone add/subtract controller.
//   state_e      : controller FSM states
//   DefaultSlice : default width of the shared Kogge-Stone slice
//   idx_width()  : width of the slice-pass index, never less than one bit
package ksa_ctrl_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_e;

   localparam int unsigned DefaultSlice = 8;

   function automatic int unsigned idx_width(input int unsigned nslice);
      return (nslice > 1) ? unsigned'($clog2(nslice)) : 1;
   endfunction

endpackage

// File: rtl/ksa_multicycle_add_ctrl_if.sv
// Request/response bundle for ksa_multicycle_add_ctrl.
//   in_valid/in_ready   : request handshake (requester -> block)
//   in1, in2, cin, sub  : operands, carry-in and subtract select
//   out_valid/out_ready : result handshake (block -> consumer)
//   out, cout           : registered result and final carry (1 = no borrow on subtract)
//   busy                : an operation is in flight or waiting to be taken
// master = requester/consumer side, slave = the controller.
interface ksa_multicycle_add_ctrl_if #(
   parameter int unsigned WIDTH = 32
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in1;
   logic [WIDTH-1:0] in2;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out;
   logic             cout;
   logic             busy;

   modport master (
      output in_valid, in1, in2, cin, sub, out_ready,
      input  in_ready, out_valid, out, cout, busy
   );

   modport slave (
      input  in_valid, in1, in2, cin, sub, out_ready,
      output in_ready, out_valid, out, cout, busy
   );

endinterface

// File: rtl/ksa_multicycle_add_ctrl_slice.sv
// Combinational SLICE-bit Kogge-Stone adder with carry-in.
//   in1, in2 : slice operands
//   cin      : carry into bit 0
//   out      : slice sum
//   cout     : carry out of the top bit
// The carry-in is folded into the bit-0 generate, so after the prefix tree each
// group generate g[i] is directly the carry into bit i+1.
module ksa_slice_cin
   import ksa_ctrl_pkg::*;
#(
   parameter int unsigned SLICE = DefaultSlice
) (
   input  logic [SLICE-1:0] in1,
   input  logic [SLICE-1:0] in2,
   input  logic             cin,
   output logic [SLICE-1:0] out,
   output logic             cout
);

   localparam int unsigned Levels = (SLICE > 1) ? unsigned'($clog2(SLICE)) : 0;

   logic [SLICE-1:0] p0;
   logic [SLICE-1:0] g0;
   logic [SLICE-1:0] grp_g;
   logic [SLICE-1:0] grp_p;
   logic [SLICE-1:0] nxt_g;
   logic [SLICE-1:0] nxt_p;
   logic [SLICE:0]   carries;

   always_comb begin
      p0    = in1 ^ in2;
      g0    = in1 & in2;
      g0[0] = g0[0] | (p0[0] & cin);

      grp_g = g0;
      grp_p = p0;
      nxt_g = g0;
      nxt_p = p0;
      // Level l combines each bit with the group 2^l positions below it.
      for (int l = 0; l < Levels; l++) begin
         nxt_g = grp_g;
         nxt_p = grp_p;
         for (int i = (1 << l); i < SLICE; i++) begin
            nxt_g[i] = grp_g[i] | (grp_p[i] & grp_g[i - (1 << l)]);
            nxt_p[i] = grp_p[i] & grp_p[i - (1 << l)];
         end
         grp_g = nxt_g;
         grp_p = nxt_p;
      end

      carries = {grp_g, cin};
      out     = p0 ^ carries[SLICE-1:0];
      cout    = carries[SLICE];
   end

endmodule

// File: rtl/ksa_multicycle_add_ctrl.sv
// Multi-cycle WIDTH-bit add/subtract built from one shared SLICE-bit Kogge-Stone slice.
//   clk, rst : single clock, synchronous active-high reset
//   bus      : slave side of ksa_multicycle_add_ctrl_if (request, result and busy)
// A request is captured in IDLE (subtract becomes a + ~b + 1), then RUN makes one slice
// pass per cycle, lowest slice first, chaining the carry through a register. On the last
// pass the completed result and carry are loaded into the output registers and the block
// waits in DONE until the consumer takes the result.
module ksa_multicycle_add_ctrl
   import ksa_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SLICE = DefaultSlice
) (
   input logic                     clk,
   input logic                     rst,
   ksa_multicycle_add_ctrl_if.slave bus
);

   localparam int unsigned     NSLICE  = WIDTH / SLICE;
   localparam int unsigned     IDXW    = idx_width(NSLICE);
   localparam logic [IDXW-1:0] LastIdx = IDXW'(NSLICE - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic [IDXW-1:0]  idx_q, idx_d;

   logic [SLICE-1:0] slice_a;
   logic [SLICE-1:0] slice_b;
   logic [SLICE-1:0] slice_sum;
   logic             slice_cout;
   logic [WIDTH-1:0] res_merged;

   // Select the operand slice for the current pass.
   always_comb begin
      slice_a = '0;
      slice_b = '0;
      for (int k = 0; k < NSLICE; k++) begin
         if (idx_q == IDXW'(k)) begin
            slice_a = a_q[k*SLICE +: SLICE];
            slice_b = b_q[k*SLICE +: SLICE];
         end
      end
   end

   ksa_slice_cin #(
      .SLICE (SLICE)
   ) u_slice (
      .in1  (slice_a),
      .in2  (slice_b),
      .cin  (carry_q),
      .out  (slice_sum),
      .cout (slice_cout)
   );

   // Result with the current pass written in; on the last pass this is the full answer.
   always_comb begin
      res_merged = res_q;
      for (int k = 0; k < NSLICE; k++) begin
         if (idx_q == IDXW'(k)) begin
            res_merged[k*SLICE +: SLICE] = slice_sum;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      carry_d = carry_q;
      idx_d   = idx_q;
      out_d   = out_q;
      cout_d  = cout_q;

      unique case (state_q)
         StIdle: begin
            if (bus.in_valid) begin
               a_d     = bus.in1;
               b_d     = bus.sub ? ~bus.in2 : bus.in2;
               carry_d = bus.sub | bus.cin;
               idx_d   = '0;
               state_d = StRun;
            end
         end
         StRun: begin
            res_d   = res_merged;
            carry_d = slice_cout;
            idx_d   = idx_q + 1'b1;
            if (idx_q == LastIdx) begin
               idx_d   = '0;
               out_d   = res_merged;
               cout_d  = slice_cout;
               state_d = StDone;
            end
         end
         StDone: begin
            if (bus.out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         out_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         carry_q <= carry_d;
         idx_q   <= idx_d;
         out_q   <= out_d;
         cout_q  <= cout_d;
      end
   end

   assign bus.in_ready  = (state_q == StIdle);
   assign bus.out_valid = (state_q == StDone);
   assign bus.busy      = (state_q != StIdle);
   assign bus.out       = out_q;
   assign bus.cout      = cout_q;

endmodule
